// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 4-digit BCD scan controller.
// Also consumed by the bcd_7_seg decoder and its benches.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

  typedef logic [NUM_DIGITS*DIGIT_W-1:0] frame_t;
  typedef logic [1:0] dig_idx_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] bcd;
    logic [NUM_DIGITS-1:0] an_n;
  } disp_t;

  // Digit k is blanked when it and every higher digit is zero.
  // Digit 0 is always shown.
  function automatic disp_t disp_digit(
    frame_t frame,
    dig_idx_t k,
    logic lzb
  );
    logic [DIGIT_W-1:0] d;
    logic hz;
    disp_t r;
    d = frame[{k, 2'b00} +: DIGIT_W];
    hz = (k != 2'd0) && ((frame >> {k, 2'b00}) == '0);
    if (lzb && hz) begin
      r.bcd = BCD_BLANK;
      r.an_n = '1;
    end else begin
      r.bcd = (d > 4'd9) ? BCD_BLANK : d;
      r.an_n = ~(4'b0001 << k);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake between a digit producer and the scan controller.
// The producer is the master; the controller is the slave.
import seg_pkg::*;

interface seg_scan_ctrl_if;
  frame_t digits_in;
  logic load_valid;
  logic load_ready;

  modport master (
    output digits_in,
    output load_valid,
    input load_ready
  );

  modport slave (
    input digits_in,
    input load_valid,
    output load_ready
  );
endinterface

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks.
// Tick is high while the count sits at CLK_DIV-1.
module seg_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input logic clk,
  input logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count up and wrap to zero on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with double-buffered load.
// Frames swap only at the frame boundary, so a scan never tears.
import seg_pkg::*;

module seg_scan_ctrl #(
  parameter int CLK_DIV = 50000
) (
  input logic clk,
  input logic rst_n,
  seg_scan_ctrl_if.slave ld,
  input logic lzb_en,
  output logic [DIGIT_W-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0] an_n
);

  logic tick;
  dig_idx_t idx;
  frame_t active;
  frame_t pending;
  logic pending_full;
  logic accept;
  logic xfer;
  disp_t nxt;

  seg_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick)
  );

  assign ld.load_ready = ~pending_full;
  assign accept = ld.load_valid & ~pending_full;
  assign xfer = tick & (idx == 2'd3) & pending_full;

  // Decode the slot being loaded into the output register.
  always_comb begin
    nxt = disp_digit(active, idx, lzb_en);
  end

  // Step the digit slot once per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx <= '0;
    else if (tick) idx <= idx + 2'd1;
  end

  // Outputs change only on tick and hold between ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out <= BCD_BLANK;
      an_n <= '1;
    end else if (tick) begin
      bcd_out <= nxt.bcd;
      an_n <= nxt.an_n;
    end
  end

  // Capture into pending; promote to active at the frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      active <= '0;
      pending_full <= 1'b0;
    end else if (xfer) begin
      active <= pending;
      pending_full <= 1'b0;
    end else if (accept) begin
      pending <= ld.digits_in;
      pending_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV = 4.
// Table of frames plus handshake and reset-mid-frame sequences.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lzb_en = 1'b0;
  logic [3:0] bcd_out;
  logic [3:0] an_n;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  seg_scan_ctrl_if ld();

  seg_scan_ctrl #(
    .CLK_DIV(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ld(ld),
    .lzb_en(lzb_en),
    .bcd_out(bcd_out),
    .an_n(an_n)
  );

  always #5 clk = ~clk;

  // Posedges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0] frame;
    logic lzb;
    logic [15:0] bcd;
    logic [15:0] an;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic goto(int c);
    int n;
    n = 0;
    while (cyc < c && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc != c) begin
      failures++;
      $display("FAIL sched got=%0d want=%0d", cyc, c);
    end
  endtask

  task automatic chk_disp(string name, logic [3:0] b, logic [3:0] a);
    chk({name, "_bcd"}, {28'd0, bcd_out}, {28'd0, b});
    chk({name, "_an"}, {28'd0, an_n}, {28'd0, a});
  endtask

  initial begin
    int base;
    vecs[0] = '{16'h1234, 1'b0, 16'h1234, 16'h7BDE};
    vecs[1] = '{16'h0070, 1'b1, 16'hFF70, 16'hFFDE};
    vecs[2] = '{16'h0000, 1'b1, 16'hFFF0, 16'hFFFE};
    vecs[3] = '{16'hA9F0, 1'b0, 16'hF9F0, 16'h7BDE};
    vecs[4] = '{16'h0000, 1'b0, 16'h0000, 16'h7BDE};
    vecs[5] = '{16'h0105, 1'b1, 16'hF105, 16'hFBDE};
    vecs[6] = '{16'h9876, 1'b1, 16'h9876, 16'h7BDE};

    ld.digits_in = '0;
    ld.load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_disp("rst", 4'hF, 4'hF);
    chk("rst_ready", {31'd0, ld.load_ready}, 32'd1);
    rst_n = 1'b1;
    goto(3);
    chk_disp("pre_tick", 4'hF, 4'hF);
    goto(4);
    chk_disp("first_d0", 4'h0, 4'hE);

    for (int i = 0; i < 7; i++) begin
      base = 32 * (i + 1);
      goto(base - 8);
      lzb_en = vecs[i].lzb;
      ld.digits_in = vecs[i].frame;
      ld.load_valid = 1'b1;
      @(negedge clk);
      ld.load_valid = 1'b0;
      chk("ld_ready", {31'd0, ld.load_ready}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        goto(base + 4 * k + 4);
        chk_disp($sformatf("v%0d_d%0d", i, k),
                 vecs[i].bcd[4*k +: 4], vecs[i].an[4*k +: 4]);
        goto(base + 4 * k + 7);
        chk_disp($sformatf("v%0d_h%0d", i, k),
                 vecs[i].bcd[4*k +: 4], vecs[i].an[4*k +: 4]);
      end
    end

    goto(248);
    lzb_en = 1'b0;
    ld.digits_in = 16'h1111;
    ld.load_valid = 1'b1;
    goto(249);
    ld.digits_in = 16'h2222;
    chk("hs_busy0", {31'd0, ld.load_ready}, 32'd0);
    goto(252);
    chk("hs_busy1", {31'd0, ld.load_ready}, 32'd0);
    goto(255);
    chk("hs_busy2", {31'd0, ld.load_ready}, 32'd0);
    goto(256);
    chk("hs_free", {31'd0, ld.load_ready}, 32'd1);
    goto(257);
    chk("hs_take", {31'd0, ld.load_ready}, 32'd0);
    ld.load_valid = 1'b0;
    goto(260);
    chk_disp("hs_d0", 4'h1, 4'hE);
    goto(264);
    chk_disp("hs_d1", 4'h1, 4'hD);
    goto(268);
    chk_disp("hs_d2", 4'h1, 4'hB);
    goto(272);
    chk_disp("hs_d3", 4'h1, 4'h7);
    goto(275);
    chk_disp("hs_d3h", 4'h1, 4'h7);
    goto(276);
    chk_disp("hs_next", 4'h2, 4'hE);

    goto(294);
    ld.digits_in = 16'h5555;
    ld.load_valid = 1'b1;
    goto(295);
    ld.load_valid = 1'b0;
    chk("mr_full", {31'd0, ld.load_ready}, 32'd0);
    goto(297);
    chk_disp("mr_pre", 4'h2, 4'hD);
    rst_n = 1'b0;
    #1;
    chk_disp("mr_rst", 4'hF, 4'hF);
    chk("mr_ready", {31'd0, ld.load_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(1);
    chk("mr_ready2", {31'd0, ld.load_ready}, 32'd1);
    goto(3);
    chk_disp("mr_dark", 4'hF, 4'hF);
    goto(4);
    chk_disp("mr_d0", 4'h0, 4'hE);
    goto(8);
    chk_disp("mr_d1", 4'h0, 4'hD);
    goto(16);
    chk_disp("mr_d3", 4'h0, 4'h7);
    goto(20);
    chk_disp("mr_nf", 4'h0, 4'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
